// File: rtl/integer_dot_pkg.sv
// Shared types and helpers for the integer datapath blocks: FSM state encoding,
// accumulator width rule and sign-extend / range-check helpers.
package integer_dot_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REDUCE = 2'd2,
    OUTPUT = 2'd3
  } dot_state_t;

  // Widest value the helpers handle; accumulators must fit inside it.
  localparam int MAX_W = 128;

  function automatic int acc_bits_for(input int bits, input int length);
    return 2 * bits + $clog2(length);
  endfunction

  // Extend the low 'width' bits of value to MAX_W, signed or unsigned.
  function automatic logic [MAX_W-1:0] ext_to_max(input logic [MAX_W-1:0] value,
                                                  input int width,
                                                  input logic is_signed);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) r[i] = value[i];
      else           r[i] = is_signed & value[width-1];
    end
    return r;
  endfunction

  // True when an extended value is representable in 'bits' bits.
  function automatic logic fits_in(input logic [MAX_W-1:0] value,
                                   input int bits,
                                   input logic is_signed);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_W; i++) begin
      if (is_signed) begin
        if (i >= bits - 1 && value[i] != value[bits-1]) ok = 1'b0;
      end else begin
        if (i >= bits && value[i]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/integer_adder_tree.sv
// Pipelined pairwise reduction of LANES accumulators, one register per tree level,
// laid out as a heap (node j sums children 2j and 2j+1; leaves are indices LANES..2*LANES-1).
module integer_adder_tree
  import integer_dot_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int ACC_BITS = 36
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [LANES*ACC_BITS-1:0] leaves,
  output logic [ACC_BITS-1:0]       root
);

  if (LANES == 1) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rstn;
    assign root = leaves;
  end else begin : g_tree
    logic [ACC_BITS-1:0] sum [1:LANES-1];
    logic [ACC_BITS-1:0] kid [2:2*LANES-1];

    for (genvar k = 2; k < 2 * LANES; k++) begin : g_kid
      if (k >= LANES) begin : g_leaf
        assign kid[k] = leaves[(k-LANES)*ACC_BITS +: ACC_BITS];
      end else begin : g_node
        assign kid[k] = sum[k];
      end
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        for (int j = 1; j < LANES; j++) sum[j] <= '0;
      end else begin
        for (int j = 1; j < LANES; j++) sum[j] <= kid[2*j] + kid[2*j+1];
      end
    end

    assign root = sum[1];
  end

endmodule

// File: rtl/integer_vector_dot_vector_tree.sv
// Streaming dot product: per-lane MACs, registered adder tree, valid/ready result.
// Define DOT_SATURATE_EN to clamp the result to BITS and add the sticky sat output.
//
// state  | meaning
// IDLE   | waiting for the first beat of a vector
// ACCUM  | accumulating beats, bubbles allowed
// REDUCE | adder tree draining, inputs blocked
// OUTPUT | result held on c until out_ready
module integer_vector_dot_vector_tree
  import integer_dot_pkg::*;
#(
  parameter int BITS     = 16,
  parameter int LANES    = 4,
  parameter int LENGTH   = 32,
  parameter int SIGNED   = 0,
  parameter int ACC_BITS = acc_bits_for(BITS, LENGTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*BITS-1:0] vector_a,
  input  logic [LANES*BITS-1:0] vector_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS-1:0]       c,
  output logic                  busy
`ifdef DOT_SATURATE_EN
  ,
  output logic                  sat
`endif
);

  localparam int BEATS   = LENGTH / LANES;
  localparam int BEAT_W  = $clog2(BEATS + 1);
  localparam int LEVELS  = $clog2(LANES);
  localparam int STAGE_W = (LEVELS > 0) ? $clog2(LEVELS + 1) : 1;

  if (LENGTH % LANES != 0) begin : g_bad_length
    $error("LENGTH must be a multiple of LANES");
  end
  if (LANES < 1 || LANES > 32 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
    $error("LANES must be a power of two in 1..32");
  end

  dot_state_t             state;
  logic [BEAT_W-1:0]      beat;
  logic [STAGE_W-1:0]     stage;
  logic                   accept;
  logic                   load;
  logic                   add;
  logic [LANES*ACC_BITS-1:0] leaves;
  logic [ACC_BITS-1:0]    root;
  logic [BITS-1:0]        result;
  logic                   clamped;

  assign accept = in_valid && in_ready;
  assign load   = accept && (state == IDLE);
  assign add    = accept && (state == ACCUM);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic                a_sgn;
    logic                b_sgn;
    logic [2*BITS-1:0]   a_ext;
    logic [2*BITS-1:0]   b_ext;
    logic [2*BITS-1:0]   prod;
    logic [ACC_BITS-1:0] prod_ext;
    logic [ACC_BITS-1:0] acc;

    // Operands are pre-extended so the low 2*BITS of the product are exact in both modes.
    assign a_sgn = (SIGNED != 0) && vector_a[i*BITS+BITS-1];
    assign b_sgn = (SIGNED != 0) && vector_b[i*BITS+BITS-1];
    assign a_ext = {{BITS{a_sgn}}, vector_a[i*BITS +: BITS]};
    assign b_ext = {{BITS{b_sgn}}, vector_b[i*BITS +: BITS]};
    assign prod  = a_ext * b_ext;

    if (SIGNED != 0) begin : g_sext
      assign prod_ext = ACC_BITS'($signed(prod));
    end else begin : g_zext
      assign prod_ext = ACC_BITS'(prod);
    end

    always_ff @(posedge clk) begin
      if (!rstn)     acc <= '0;
      else if (load) acc <= prod_ext;
      else if (add)  acc <= acc + prod_ext;
    end

    assign leaves[i*ACC_BITS +: ACC_BITS] = acc;
  end

  integer_adder_tree #(
    .LANES    (LANES),
    .ACC_BITS (ACC_BITS)
  ) u_tree (
    .clk    (clk),
    .rstn   (rstn),
    .leaves (leaves),
    .root   (root)
  );

`ifdef DOT_SATURATE_EN
  logic [MAX_W-1:0] root_wide;
  logic             root_fits;
  logic [BITS-1:0]  clamp_val;

  assign root_wide = ext_to_max(MAX_W'(root), ACC_BITS, SIGNED != 0);
  assign root_fits = fits_in(root_wide, BITS, SIGNED != 0);
  assign clamp_val = (SIGNED != 0) ? {root[ACC_BITS-1], {(BITS-1){~root[ACC_BITS-1]}}} : '1;
  assign result    = root_fits ? root[BITS-1:0] : clamp_val;
  assign clamped   = ~root_fits;
`else
  logic unused_root_hi;
  assign unused_root_hi = ^root[ACC_BITS-1:BITS];
  assign result  = root[BITS-1:0];
  assign clamped = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      beat      <= '0;
      stage     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      c         <= '0;
      busy      <= 1'b0;
`ifdef DOT_SATURATE_EN
      sat       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            beat <= BEAT_W'(1);
            busy <= 1'b1;
            if (BEATS == 1) begin
              state    <= REDUCE;
              in_ready <= 1'b0;
              stage    <= STAGE_W'(LEVELS);
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            beat <= beat + 1'b1;
            if (beat == BEAT_W'(BEATS - 1)) begin
              state    <= REDUCE;
              in_ready <= 1'b0;
              stage    <= STAGE_W'(LEVELS);
            end
          end
        end
        REDUCE: begin
          // Stage count covers the tree levels; the extra cycle latches the root.
          if (stage == '0) begin
            state     <= OUTPUT;
            out_valid <= 1'b1;
            c         <= result;
`ifdef DOT_SATURATE_EN
            sat       <= clamped;
`endif
          end else begin
            stage <= stage - 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state     <= IDLE;
            beat      <= '0;
            out_valid <= 1'b0;
            c         <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
`ifdef DOT_SATURATE_EN
            sat       <= 1'b0;
`endif
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifndef DOT_SATURATE_EN
  logic unused_clamped;
  assign unused_clamped = clamped;
`endif

endmodule
